// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console and simulation-control peripheral.
// Decodes an I/O page on the shared CPU data bus. Bytes written to TX are
// buffered in a FIFO and drained through a paced valid/ready byte stream.
// It also provides a free-running cycle counter and a sticky halt register.
//
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   mem_addr/wdata/wmask : CPU bus write request (wmask != 0 means write)
//   mem_rstrb            : CPU bus read strobe
//   io_sel               : combinational page select, equal to mem_addr[IO_BIT]
//   io_rdata             : registered read data, one-cycle latency
//   io_rbusy / io_wbusy  : read stall (always 0) / write stall while TX is full
//   tx_valid/data/ready  : paced byte stream out of the TX FIFO
//   halt, halt_code      : sticky halt flag and the last word written to HALT
module mmio_console #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 4,
  parameter int unsigned IO_BIT     = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        io_rbusy,
  output logic        io_wbusy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(DRAIN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OFS_TX     = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CYCLE  = 2'd2;
  localparam logic [1:0] OFS_HALT   = 2'd3;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              halt_q, halt_d;
  logic [31:0]       halt_code_q, halt_code_d;
  logic [31:0]       cycle_q, cycle_d;

  logic [1:0]  offset_c;
  logic        full_c, empty_c, tx_req_c, push_c, pop_c;
  logic [31:0] status_c;
  logic        unused_c;

  // Address decode and FIFO handshake terms (full is the pre-edge value)
  assign io_sel   = mem_addr[IO_BIT];
  assign offset_c = mem_addr[3:2];
  assign full_c   = (count_q == CNT_FULL);
  assign empty_c  = (count_q == '0);
  assign tx_req_c = io_sel && (offset_c == OFS_TX) && mem_wmask[0];
  assign push_c   = tx_req_c && !full_c;
  assign io_wbusy = tx_req_c && full_c;
  assign io_rbusy = 1'b0;
  assign tx_valid = !empty_c && (pace_q == '0);
  assign pop_c    = tx_valid && tx_ready;
  assign tx_data  = mem_q[rd_ptr_q];

  assign io_rdata  = rdata_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

  // Only the page bit and word offset of the address are decoded
  assign unused_c = ^mem_addr;

  // STATUS word: full, empty and occupancy count
  always_comb begin
    status_c              = '0;
    status_c[0]           = full_c;
    status_c[1]           = empty_c;
    status_c[8 +: CNT_W]  = count_q;
  end

  // Next-state logic for FIFO, pacing, halt, counter and read data
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pace_d      = pace_q;
    rdata_d     = rdata_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    cycle_d     = cycle_q + 32'd1;

    if (push_c) begin
      mem_d[wr_ptr_q] = mem_wdata[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // Pace reloads on every pop so consecutive handshakes are DRAIN_DIV apart
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      pace_d   = PACE_RELOAD;
    end else if (pace_q != '0) begin
      pace_d = pace_q - PACE_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (io_sel && (offset_c == OFS_HALT) && (mem_wmask != 4'b0000)) begin
      halt_d      = 1'b1;
      halt_code_d = mem_wdata;
    end

    if (mem_rstrb && io_sel) begin
      case (offset_c)
        OFS_STATUS: rdata_d = status_c;
        OFS_CYCLE:  rdata_d = cycle_q;
        OFS_HALT:   rdata_d = {31'b0, halt_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pace_q      <= '0;
      rdata_q     <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cycle_q     <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pace_q      <= pace_d;
      rdata_q     <= rdata_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: scoreboard bench for mmio_console. Stimulus pushes the
// expected TX bytes and read words into queues; a monitor on the falling
// edge pops and compares whenever a handshake or a read result appears.
module tb_mmio_console;

  localparam logic [31:0] IO      = 32'h0040_0000;
  localparam logic [31:0] A_TX    = IO | 32'h0;
  localparam logic [31:0] A_STAT  = IO | 32'h4;
  localparam logic [31:0] A_CYCLE = IO | 32'h8;
  localparam logic [31:0] A_HALT  = IO | 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        io_rbusy;
  logic        io_wbusy;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [31:0] halt_code;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = -1;
  bit check_gap = 1'b0;

  logic [7:0]  exp_tx [$];
  logic [31:0] exp_rd [$];

  mmio_console dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .io_sel(io_sel),
    .io_rdata(io_rdata), .io_rbusy(io_rbusy), .io_wbusy(io_wbusy),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares TX handshakes and read results against the queues
  bit rd_pending = 1'b0;
  always @(negedge clk) begin
    if (rd_pending) begin
      if (exp_rd.size() == 0) check32("rd_unexpected", io_rdata, 32'hxxxx_xxxx);
      else check32("rd_data", io_rdata, exp_rd.pop_front());
    end
    rd_pending = mem_rstrb && io_sel && !reset;
    if (!reset && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL tx_unexpected: got 0x%02h, expected no handshake", tx_data);
      end else begin
        check32("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (check_gap && last_hs >= 0) check32("tx_gap", 32'(cyc - last_hs), 32'd4);
      last_hs = cyc;
    end
  end

  // Tasks are entered and left at posedge+1
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int budget = 200;
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    while (io_wbusy && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    if (budget == 0) check32("write_timeout", 32'(io_wbusy), 32'd0);
    @(posedge clk); #1;
    mem_wmask = '0; mem_addr = '0;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp);
    exp_rd.push_back(exp);
    mem_addr = a; mem_rstrb = 1'b1;
    @(posedge clk); #1;
    mem_rstrb = 1'b0; mem_addr = '0;
  endtask

  task automatic drain_wait(input int budget);
    while (exp_tx.size() != 0 && budget > 0) begin
      @(posedge clk); #1; budget--;
    end
    check32("drain_left", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state
    idle(3);
    check32("rst_rdata", io_rdata, 32'h0);
    check32("rst_txvalid", 32'(tx_valid), 32'd0);
    check32("rst_txdata", 32'(tx_data), 32'd0);
    reset = 1'b0;
    cpu_read(A_CYCLE, 32'h0);
    cpu_read(A_STAT, 32'h0000_0002);
    check32("rst_halt", 32'(halt), 32'd0);
    check32("rbusy", 32'(io_rbusy), 32'd0);
    idle(2);

    // Three bytes, paced four cycles apart
    tx_ready = 1'b1; last_hs = -1; check_gap = 1'b1;
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h42); exp_tx.push_back(8'h43);
    cpu_write(A_TX, 32'h41, 4'b0001);
    cpu_write(A_TX, 32'h42, 4'b0001);
    cpu_write(A_TX, 32'h43, 4'b0001);
    drain_wait(40);
    idle(6);

    // Fill to full with the sink stalled, then a stalled 17th write
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_tx.push_back(8'(i));
      cpu_write(A_TX, 32'(i), 4'b0001);
    end
    cpu_read(A_STAT, 32'h0000_1001);
    exp_tx.push_back(8'd16);
    mem_addr = A_TX; mem_wdata = 32'd16; mem_wmask = 4'b0001;
    #1 check32("full_wbusy", 32'(io_wbusy), 32'd1);
    idle(2);
    check32("full_hold_wbusy", 32'(io_wbusy), 32'd1);
    last_hs = -1; tx_ready = 1'b1;
    #1 check32("pop_cycle_wbusy", 32'(io_wbusy), 32'd1);
    @(posedge clk); #1;
    check32("after_pop_wbusy", 32'(io_wbusy), 32'd0);
    @(posedge clk); #1;
    mem_wmask = '0; mem_addr = '0;
    drain_wait(200);
    idle(6);

    // Offset 0 write without byte lane 0 is ignored
    mem_addr = A_TX; mem_wdata = 32'h55; mem_wmask = 4'b0010;
    #1 check32("mask_wbusy", 32'(io_wbusy), 32'd0);
    @(posedge clk); #1;
    mem_wmask = '0; mem_addr = '0;
    tx_ready = 1'b0;
    cpu_read(A_STAT, 32'h0000_0002);

    // Halt register
    cpu_write(A_HALT, 32'hDEAD_BEEF, 4'b1111);
    check32("halt_set", 32'(halt), 32'd1);
    check32("halt_code1", halt_code, 32'hDEAD_BEEF);
    cpu_read(A_HALT, 32'h1);
    cpu_write(A_HALT, 32'h1, 4'b0001);
    check32("halt_sticky", 32'(halt), 32'd1);
    check32("halt_code2", halt_code, 32'h1);

    // Reset mid-operation clears halt and discards queued bytes
    cpu_write(A_TX, 32'hA5, 4'b0001);
    cpu_write(A_TX, 32'h5A, 4'b0001);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check32("rst2_halt", 32'(halt), 32'd0);
    check32("rst2_code", halt_code, 32'h0);
    cpu_read(A_STAT, 32'h0000_0002);
    tx_ready = 1'b1;
    idle(10);

    // Cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    @(posedge clk); #1;
    cpu_read(A_CYCLE, 32'hFFFF_FFFF);
    cpu_read(A_CYCLE, 32'h0000_0000);
    idle(3);
    check32("rd_queue_left", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
